regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
// - Owns the single write port of the 32x32 RISC-V register file.
// - Arbitrates between two writeback requesters: ALU (req0) and load unit (req1).
// - Keeps a pending-write scoreboard; decode reserves rd at issue and queries rs1/rs2 hazards.
// - Sits between execute/memory stages and the register file (drives WD/A3/RegWrite).
// PARAMETERS
// - XLEN  32  data width of write port
// - AW    5   register address width (2**AW registers, x0 hard-wired zero)
// PORTS
// - CLK        in   1     clock, all state updates on posedge
// - RST        in   1     synchronous, active-high reset
// - EN         in   1     block enable; 0 freezes all state
// - rsv_valid  in   1     decode requests reservation of rsv_rd
// - rsv_rd     in   AW    destination register to reserve
// - rsv_ready  out  1     reservation accepted this cycle
// - q_rs1      in   AW    hazard query source 1
// - q_rs2      in   AW    hazard query source 2
// - hazard     out  1     q_rs1 or q_rs2 has a pending write
// - alu_valid  in   1     ALU writeback request
// - alu_rd     in   AW    ALU destination
// - alu_data   in   XLEN  ALU result
// - alu_ready  out  1     ALU request granted this cycle
// - lsu_valid  in   1     load writeback request
// - lsu_rd     in   AW    load destination
// - lsu_data   in   XLEN  load data
// - lsu_ready  out  1     load request granted this cycle
// - rf_we      out  1     to RegFile RegWrite
// - rf_wa      out  AW    to RegFile A3
// - rf_wd      out  XLEN  to RegFile WD
// - pending    out  2**AW scoreboard bit vector (bit0 always 0)
// BEHAVIOUR
// - Reset: pending=0, rf_we=0, rf_wa=0, rf_wd=0, RR pointer favours lsu; ready outputs 0 while RST=1.
// - Handshake: valid/ready. Requester holds rd/data stable until ready; transfer when valid&ready.
// - ready is combinational from valid, EN, and arbitration state; at most one grant per cycle.
// - Latency: granted request appears on rf_we/rf_wa/rf_wd the next cycle (registered), one cycle wide.
// - No grant in a cycle -> rf_we=0 next cycle; rf_wa/rf_wd hold their last values.
// - rd==0 write: granted normally, but rf_we=0 (x0 never written).
// - Scoreboard: grant clears pending[rd] at the grant edge; accepted reservation sets pending[rsv_rd].
// - Same-cycle grant-clear and reserve of same rd: set wins, pending stays 1.
// - rsv_ready=0 if pending[rsv_rd]=1 and not cleared this cycle (WAW stall); rsv_rd=0 always accepted, no set.
// - hazard = (pending[q_rs1]&(q_rs1!=0)) | (pending[q_rs2]&(q_rs2!=0)); combinational, uses registered pending only (no bypass).
// - EN=0: alu_ready=lsu_ready=rsv_ready=0, rf_we=0 next cycle, pending and pointer frozen; hazard still valid.
// - RST mid-handshake: request dropped, pending cleared; requester must re-present after reset.
// CONFIGURATION
// - REGFILE_WB_RR_EN defined: 2-way round-robin; pointer toggles to the non-granted requester after each grant.
// - REGFILE_WB_RR_EN undefined: fixed priority, lsu over alu; pointer logic removed.
// STRUCTURE
// - Package regfile_pkg: XLEN, AW, NREG, requester-id constants REQ_ALU=0, REQ_LSU=1.
// - Sub-module rr_arb2: 2-input arbiter (grant vector + pointer register), honours REGFILE_WB_RR_EN.
// - Top holds scoreboard register, write-port output registers, reservation logic.
// TESTING
// - Reset: RST=1 for 2 cycles with all valids high -> readys 0, pending=0, rf_we=0.
// - Single ALU write x5=0xDEADBEEF after reserve x5 -> alu_ready same cycle, next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, pending[5]=0.
// - Contention, alu x3 and lsu x4 both valid 4 cycles -> RR: lsu,alu,lsu,alu grants; fixed: lsu first, then alu.
// - Reserve x7 while pending[7]=1 and no grant -> rsv_ready=0; same cycle as x7 grant -> rsv_ready=1, pending[7] stays 1.
// - Hazard: pending[9]=1, q_rs1=9 -> hazard=1; q_rs1=0,q_rs2=0 with any pending -> hazard=0.
// - x0 and EN: lsu write rd=0 -> lsu_ready=1, rf_we=0; EN=0 with alu_valid=1 -> alu_ready=0, state unchanged.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    // Requester ids double as bit positions in the arbiter request/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } reqIdT;

    typedef logic [AW-1:0]   regAddrT;
    typedef logic [XLEN-1:0] dataT;

    function automatic logic [NREG-1:0] oneHot(input regAddrT idx);
        return NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Decode, writeback-requester and register-file write-port bundle of the scheduler.
interface regfile_wb_scheduler_if import regfile_pkg::*; ();

    logic            rsv_valid;
    regAddrT         rsv_rd;
    logic            rsv_ready;
    regAddrT         q_rs1;
    regAddrT         q_rs2;
    logic            hazard;
    logic            alu_valid;
    regAddrT         alu_rd;
    dataT            alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    regAddrT         lsu_rd;
    dataT            lsu_data;
    logic            lsu_ready;
    logic            rf_we;
    regAddrT         rf_wa;
    dataT            rf_wd;
    logic [NREG-1:0] pending;

    modport master (
        output rsv_valid, rsv_rd, q_rs1, q_rs2,
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  rsv_ready, hazard, alu_ready, lsu_ready,
        input  rf_we, rf_wa, rf_wd, pending
    );

    modport slave (
        input  rsv_valid, rsv_rd, q_rs1, q_rs2,
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output rsv_ready, hazard, alu_ready, lsu_ready,
        output rf_we, rf_wa, rf_wd, pending
    );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-input writeback arbiter: round-robin when REGFILE_WB_RR_EN is defined,
// otherwise fixed priority with the load unit ahead of the ALU.
module rr_arb2 import regfile_pkg::*; (
`ifdef REGFILE_WB_RR_EN
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef REGFILE_WB_RR_EN
    reqIdT ptr_q, ptr_d;

    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= REQ_LSU;
        else     ptr_q <= ptr_d;
    end

    // The pointer names the favoured requester and moves to the loser after a grant.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (req_i[REQ_LSU] && (!req_i[REQ_ALU] || ptr_q == REQ_LSU)) begin
            gnt_o[REQ_LSU] = 1'b1;
        end else if (req_i[REQ_ALU]) begin
            gnt_o[REQ_ALU] = 1'b1;
        end
        if (EN) begin
            if (gnt_o[REQ_LSU])      ptr_d = REQ_ALU;
            else if (gnt_o[REQ_ALU]) ptr_d = REQ_LSU;
        end
    end
`else
    always_comb begin
        gnt_o          = '0;
        gnt_o[REQ_LSU] = req_i[REQ_LSU];
        gnt_o[REQ_ALU] = req_i[REQ_ALU] & ~req_i[REQ_LSU];
    end
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: arbitrates ALU/LSU writebacks and tracks pending writes.
// Build option: REGFILE_WB_RR_EN selects round-robin arbitration instead of fixed LSU priority.
module regfile_wb_scheduler import regfile_pkg::*; (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    regfile_wb_scheduler_if.slave  bus
);

    logic            active;
    logic [1:0]      req, gnt;
    logic            grantAny;
    regAddrT         grantRd;
    dataT            grantData;
    logic            rsvAccept;
    logic [NREG-1:0] pending_q, pending_d;
    logic            rfWe_q, rfWe_d;
    regAddrT         rfWa_q;
    dataT            rfWd_q;

    assign active = EN & ~RST;
    assign req    = {bus.lsu_valid & active, bus.alu_valid & active};

    rr_arb2 uArb (
`ifdef REGFILE_WB_RR_EN
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
`endif
        .req_i (req),
        .gnt_o (gnt)
    );

    assign bus.alu_ready = gnt[REQ_ALU];
    assign bus.lsu_ready = gnt[REQ_LSU];
    assign grantAny      = |gnt;
    assign grantRd       = gnt[REQ_LSU] ? bus.lsu_rd   : bus.alu_rd;
    assign grantData     = gnt[REQ_LSU] ? bus.lsu_data : bus.alu_data;

    // A reservation stalls on an outstanding write unless that write retires this very cycle.
    assign rsvAccept = active & bus.rsv_valid &
                       ((bus.rsv_rd == '0) | ~pending_q[bus.rsv_rd] |
                        (grantAny & (grantRd == bus.rsv_rd)));

    // Clear is applied before set so a same-cycle re-reservation keeps the bit high.
    always_comb begin
        pending_d = pending_q;
        if (grantAny)                       pending_d = pending_d & ~oneHot(grantRd);
        if (rsvAccept && bus.rsv_rd != '0)  pending_d = pending_d | oneHot(bus.rsv_rd);
        pending_d[0] = 1'b0;
        rfWe_d = grantAny & (grantRd != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= '0;
            rfWe_q    <= 1'b0;
            rfWa_q    <= '0;
            rfWd_q    <= '0;
        end else begin
            pending_q <= pending_d;
            rfWe_q    <= rfWe_d;
            if (grantAny) begin
                rfWa_q <= grantRd;
                rfWd_q <= grantData;
            end
        end
    end

    assign bus.rsv_ready = rsvAccept;
    assign bus.hazard    = (pending_q[bus.q_rs1] & (bus.q_rs1 != '0)) |
                           (pending_q[bus.q_rs2] & (bus.q_rs2 != '0));
    assign bus.rf_we     = rfWe_q;
    assign bus.rf_wa     = rfWa_q;
    assign bus.rf_wd     = rfWd_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized and directed bench for regfile_wb_scheduler against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

    logic CLK = 1'b0;
    logic RST;
    logic EN;

    always #5 CLK = ~CLK;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler dut (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .bus (bus)
    );

`ifdef REGFILE_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    // Reference state: which registers await a write, who is favoured, and the write port.
    bit          mPend[32];
    bit          mFavourLsu = 1'b1;
    bit          mWe;
    int          mWa;
    logic [31:0] mWd;

    logic seenAlu, seenLsu, seenRsv, seenHaz;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelPendingWord();
        logic [31:0] w = '0;
        for (int i = 1; i < 32; i++) w[i] = mPend[i];
        return w;
    endfunction

    // One clock: drive inputs, check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit rv, input int rrd,
                                 input int q1, input int q2,
                                 input bit av, input int ard, input logic [31:0] ad,
                                 input bit lv, input int lrd, input logic [31:0] ld);
        int          winner;
        int          wrd;
        logic [31:0] wdat;
        bit          rsvOk, expHaz;
        RST           = rst;
        EN            = en;
        bus.rsv_valid = rv;
        bus.rsv_rd    = 5'(rrd);
        bus.q_rs1     = 5'(q1);
        bus.q_rs2     = 5'(q2);
        bus.alu_valid = av;
        bus.alu_rd    = 5'(ard);
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = 5'(lrd);
        bus.lsu_data  = ld;
        #3;
        winner = -1;
        if (!rst && en) begin
            if (av && lv)  winner = (RR && !mFavourLsu) ? 0 : 1;
            else if (lv)   winner = 1;
            else if (av)   winner = 0;
        end
        wrd    = (winner == 1) ? lrd : ard;
        wdat   = (winner == 1) ? ld  : ad;
        rsvOk  = !rst && en && rv && (rrd == 0 || !mPend[rrd] || (winner >= 0 && wrd == rrd));
        expHaz = (q1 != 0 && mPend[q1]) || (q2 != 0 && mPend[q2]);
        seenAlu = bus.alu_ready;
        seenLsu = bus.lsu_ready;
        seenRsv = bus.rsv_ready;
        seenHaz = bus.hazard;
        checkOutput("alu_ready", 32'(bus.alu_ready), 32'(winner == 0));
        checkOutput("lsu_ready", 32'(bus.lsu_ready), 32'(winner == 1));
        checkOutput("rsv_ready", 32'(bus.rsv_ready), 32'(rsvOk));
        checkOutput("hazard",    32'(bus.hazard),    32'(expHaz));
        if (rst) begin
            foreach (mPend[i]) mPend[i] = 1'b0;
            mFavourLsu = 1'b1;
            mWe = 1'b0;
            mWa = 0;
            mWd = '0;
        end else begin
            mWe = (winner >= 0) && (wrd != 0);
            if (winner >= 0) begin
                mPend[wrd] = 1'b0;
                mWa        = wrd;
                mWd        = wdat;
                mFavourLsu = (winner == 0);
            end
            if (rsvOk && rrd != 0) mPend[rrd] = 1'b1;
        end
        @(posedge CLK);
        #1;
        checkOutput("rf_we",   32'(bus.rf_we), 32'(mWe));
        checkOutput("rf_wa",   32'(bus.rf_wa), 32'(mWa));
        checkOutput("rf_wd",   bus.rf_wd,      mWd);
        checkOutput("pending", bus.pending,    modelPendingWord());
    endtask

    bit          aV = 1'b0, lV = 1'b0;
    int          aRd, lRd;
    logic [31:0] aD, lD;
    logic [31:0] pendBefore;
    bit          rstR, enR;

    initial begin
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) applyStimulus(1, 1, 1, 5, 0, 0, 1, 3, 32'h1, 1, 4, 32'h2);
        checkOutput("rst_alu_ready", 32'(seenAlu), 0);
        checkOutput("rst_pending", bus.pending, 0);

        applyStimulus(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rsv5_ready", 32'(seenRsv), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("x5_alu_ready", 32'(seenAlu), 1);
        checkOutput("x5_we", 32'(bus.rf_we), 1);
        checkOutput("x5_wa", 32'(bus.rf_wa), 5);
        checkOutput("x5_wd", bus.rf_wd, 32'hDEADBEEF);
        checkOutput("x5_pending", 32'(bus.pending[5]), 0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, 1, 3, 32'(k), 1, 4, 32'(k + 100));
            checkOutput($sformatf("cont%0d_lsu", k), 32'(seenLsu), 32'(RR ? (k % 2 == 0) : 1'b1));
        end

        applyStimulus(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("waw7_stall", 32'(seenRsv), 0);
        applyStimulus(0, 1, 1, 7, 0, 0, 1, 7, 32'h77, 0, 0, 0);
        checkOutput("waw7_accept", 32'(seenRsv), 1);
        checkOutput("waw7_pending", 32'(bus.pending[7]), 1);

        applyStimulus(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haz9", 32'(seenHaz), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("haz_x0", 32'(seenHaz), 0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
        checkOutput("x0_lsu_ready", 32'(seenLsu), 1);
        checkOutput("x0_we", 32'(bus.rf_we), 0);
        pendBefore = bus.pending;
        applyStimulus(0, 0, 1, 12, 0, 0, 1, 9, 32'h99, 0, 0, 0);
        checkOutput("en0_alu_ready", 32'(seenAlu), 0);
        checkOutput("en0_pending", bus.pending, pendBefore);

        // Requesters hold their request until granted; a reset drops it.
        for (int n = 0; n < 500; n++) begin
            rstR = ($urandom_range(0, 99) == 0);
            enR  = ($urandom_range(0, 7) != 0);
            if (!aV && $urandom_range(0, 1) == 1) begin
                aV = 1'b1; aRd = $urandom_range(0, 31); aD = $urandom;
            end
            if (!lV && $urandom_range(0, 1) == 1) begin
                lV = 1'b1; lRd = $urandom_range(0, 31); lD = $urandom;
            end
            applyStimulus(rstR, enR, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31),
                          aV, aRd, aD, lV, lRd, lD);
            if (seenAlu || rstR) aV = 1'b0;
            if (seenLsu || rstR) lV = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
